alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer for the shared ALU. It accepts operation requests from two requesters over valid/ready handshakes, picks one with round-robin fairness, and drives the ALU operands and the 4-bit ALU control code for the number of cycles that operation needs. It then captures the ALU result and returns it to the winning requester with an ID tag. It sits between the instruction-side requesters and the ALU/result-mux datapath and is the only block that drives the ALU control code.

## Interface
- N, 4: data width of operands and result.
- MULT_LAT, 2: execute cycles for MULT (op 2); must be ≥1.
- DIV_LAT, 4: execute cycles for DIV (op 3); must be ≥1.

- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_op  in  4  requester 0 ALU op code.
- req0_a, req0_b  in  N  requester 0 operands.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as the requester 0 ports, for requester 1.
- alu_a, alu_b  out  N  registered operands to the ALU.
- alu_ctrl  out  4  registered ALU control code.
- alu_result  in  N  combinational ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  N  captured result.
- rsp_err  out  1  illegal op code or divide by zero.

## Operation
- Op encoding (shared with the ALU): 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SLL, 5 SRL, 6 AND, 7 OR, 8 XOR, 9 NOT. Codes 10–15 are illegal.
- Execute latency L:
  - MULT_LAT for op 2.
  - DIV_LAT for op 3.
  - 1 for every other legal op.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester that is not last_grant.
  - reqX_ready = (state==IDLE) & reqX_valid & grant==X; this is combinational.
  - A handshake is reqX_valid & reqX_ready.
  - Requesters hold valid, op and operands stable until ready.
- On a handshake:
  - Latch the id and set last_grant to id.
  - Legal op, not a divide by zero: load alu_a, alu_b and alu_ctrl; load the counter with L-1; go to EXEC.
  - Illegal op: rsp_err=1, rsp_result=0; go to RESP; alu_* unchanged.
  - DIV with b==0: rsp_err=1, rsp_result=all ones; go to RESP; alu_* unchanged.
- EXEC:
  - alu_* are held.
  - The counter decrements each cycle.
  - In the cycle with counter==0, capture alu_result into rsp_result, set rsp_err=0, go to RESP.
  - Counter width is ceil(log2(max(MULT_LAT, DIV_LAT)))+1.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err stay stable until rsp_valid & rsp_ready, then go to IDLE.
  - No request is accepted in RESP or EXEC; both readys are 0.
- alu_a, alu_b and alu_ctrl keep their last issued values outside EXEC.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - alu_a=0, alu_b=0, alu_ctrl=4'b0000.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, counter=0.
- Handshake in cycle c, legal op:
  - EXEC occupies cycles c+1 … c+L.
  - rsp_valid=1 from cycle c+L+1.
- Error path (illegal op or divide by zero): rsp_valid=1 from cycle c+1.
- Response consumed in cycle r (rsp_valid & rsp_ready): IDLE in r+1; the earliest next handshake is in r+1.
- rsp_ready high while rsp_valid=0 is ignored.
- Reset asserted at any time, including mid-EXEC or mid-RESP:
  - Outputs go to their reset values immediately.
  - The in-flight operation is discarded and no response is issued.

## Test plan
- Reset:
  - Assert rst with req0_valid=1 → all outputs at reset values and req0_ready=0 while rst is high.
  - Release rst → req0_ready=1 in the first IDLE cycle.
- req0 ADD, a=3, b=4, bench ALU model, rsp_ready=1:
  - Handshake in cycle c → alu_ctrl=0, alu_a=3, alu_b=4 in c+1.
  - Then rsp_valid in c+2 with rsp_id=0, rsp_result=7, rsp_err=0.
- req1 MULT 3×2 → rsp_valid in c+3, rsp_result=6. DIV 9/2 → rsp_valid in c+5, rsp_result=4, alu_ctrl=3 throughout EXEC.
- Both requesters valid continuously after reset, each op ADD:
  - Grants alternate 0,1,0,1.
  - Only one ready is high per IDLE cycle, and never in EXEC or RESP.
- Error cases:
  - DIV with b=0 → rsp_valid in c+1, rsp_err=1, rsp_result=4'b1111, alu_ctrl unchanged.
  - Op 4'b1100 → rsp_err=1, rsp_result=0.
- Backpressure and reset:
  - Hold rsp_ready=0 for 3 cycles in RESP → rsp fields stable and both readys 0.
  - Assert rst during cycle 2 of a DIV EXEC → rsp_valid never rises; after release, IDLE and last_grant=1.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : round-robin two-port arbiter/sequencer for the shared ALU.
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
   parameter int N        = 4,
   parameter int MULT_LAT = 2,
   parameter int DIV_LAT  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid_i,
   input  logic [3:0]   req0_op_i,
   input  logic [N-1:0] req0_a_i,
   input  logic [N-1:0] req0_b_i,
   output logic         req0_ready_o,
   input  logic         req1_valid_i,
   input  logic [3:0]   req1_op_i,
   input  logic [N-1:0] req1_a_i,
   input  logic [N-1:0] req1_b_i,
   output logic         req1_ready_o,
   output logic [N-1:0] alu_a_o,
   output logic [N-1:0] alu_b_o,
   output logic [3:0]   alu_ctrl_o,
   input  logic [N-1:0] alu_result_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic         rsp_id_o,
   output logic [N-1:0] rsp_result_o,
   output logic         rsp_err_o
);

   localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int c_CW      = $clog2(c_MAX_LAT) + 1;
   localparam logic [c_CW-1:0] c_MULT_CNT = c_CW'(MULT_LAT - 1);
   localparam logic [c_CW-1:0] c_DIV_CNT  = c_CW'(DIV_LAT - 1);
   localparam logic [3:0] c_OP_MULT = 4'd2;
   localparam logic [3:0] c_OP_DIV  = 4'd3;
   localparam logic [3:0] c_OP_MAX  = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_q;
   logic              last_grant_q;
   logic [c_CW-1:0]   cnt_q;
   logic [N-1:0]      alu_a_q;
   logic [N-1:0]      alu_b_q;
   logic [3:0]        alu_ctrl_q;
   logic              rsp_valid_q;
   logic              rsp_id_q;
   logic [N-1:0]      rsp_result_q;
   logic              rsp_err_q;

   logic              w_idle;
   logic              w_grant;
   logic              w_hs;
   logic [3:0]        w_op;
   logic [N-1:0]      w_a;
   logic [N-1:0]      w_b;
   logic              w_illegal;
   logic              w_div0;
   logic [c_CW-1:0]   w_cnt_init;

   // Readys are masked while reset is held so nothing is offered mid-reset.
   assign w_idle  = (state_q == ST_IDLE) & ~rst;
   assign w_grant = req1_valid_i & (~req0_valid_i | ~last_grant_q);

   assign req0_ready_o = w_idle & req0_valid_i & ~w_grant;
   assign req1_ready_o = w_idle & req1_valid_i &  w_grant;
   assign w_hs         = req0_ready_o | req1_ready_o;

   assign w_op = w_grant ? req1_op_i : req0_op_i;
   assign w_a  = w_grant ? req1_a_i  : req0_a_i;
   assign w_b  = w_grant ? req1_b_i  : req0_b_i;

   assign w_illegal = (w_op > c_OP_MAX);
   assign w_div0    = (w_op == c_OP_DIV) && (w_b == '0);

   always_comb begin
      w_cnt_init = '0;
      if (w_op == c_OP_MULT)
         w_cnt_init = c_MULT_CNT;
      else if (w_op == c_OP_DIV)
         w_cnt_init = c_DIV_CNT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= 4'b0000;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_hs) begin
                  last_grant_q <= w_grant;
                  rsp_id_q     <= w_grant;
                  if (w_illegal) begin
                     rsp_err_q    <= 1'b1;
                     rsp_result_q <= '0;
                     rsp_valid_q  <= 1'b1;
                     state_q      <= ST_RESP;
                  end else if (w_div0) begin
                     rsp_err_q    <= 1'b1;
                     rsp_result_q <= '1;
                     rsp_valid_q  <= 1'b1;
                     state_q      <= ST_RESP;
                  end else begin
                     alu_a_q    <= w_a;
                     alu_b_q    <= w_b;
                     alu_ctrl_q <= w_op;
                     cnt_q      <= w_cnt_init;
                     state_q    <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (cnt_q == '0) begin
                  rsp_result_q <= alu_result_i;
                  rsp_err_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_ctrl_o   = alu_ctrl_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_err_o    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : directed vector bench for alu_arbiter with a simple ALU.
// Revision       : 1.0
// ============================================================================
module tb_alu_arbiter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [3:0]   req0_op, req1_op;
   logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic [N-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_ctrl;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [N-1:0] rsp_result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N(N), .MULT_LAT(2), .DIV_LAT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid_i (req0_valid),
      .req0_op_i    (req0_op),
      .req0_a_i     (req0_a),
      .req0_b_i     (req0_b),
      .req0_ready_o (req0_ready),
      .req1_valid_i (req1_valid),
      .req1_op_i    (req1_op),
      .req1_a_i     (req1_a),
      .req1_b_i     (req1_b),
      .req1_ready_o (req1_ready),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_ctrl_o   (alu_ctrl),
      .alu_result_i (alu_result),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_id_o     (rsp_id),
      .rsp_result_o (rsp_result),
      .rsp_err_o    (rsp_err)
   );

   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'd0: alu_result = alu_a + alu_b;
         4'd1: alu_result = alu_a - alu_b;
         4'd2: alu_result = alu_a * alu_b;
         4'd3: alu_result = (alu_b != '0) ? alu_a / alu_b : '1;
         4'd4: alu_result = alu_a << alu_b;
         4'd5: alu_result = alu_a >> alu_b;
         4'd6: alu_result = alu_a & alu_b;
         4'd7: alu_result = alu_a | alu_b;
         4'd8: alu_result = alu_a ^ alu_b;
         4'd9: alu_result = ~alu_a;
         default: alu_result = '0;
      endcase
   end

   typedef struct {
      logic       id;
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      int         lat;
      logic [3:0] res;
      logic       err;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic id, input logic v, input logic [3:0] op,
                          input logic [3:0] a, input logic [3:0] b);
      if (id == 1'b0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Called just after a rising edge; leaves the bench just after a rising edge.
   task automatic run_op(input vec_t v);
      int         lat;
      bit         done;
      logic [3:0] ctrl_before;
      set_req(v.id, 1'b1, v.op, v.a, v.b);
      @(negedge clk);
      chk("hs_ready", v.id ? req1_ready : req0_ready, 1'b1);
      chk("hs_other_ready", v.id ? req0_ready : req1_ready, 1'b0);
      ctrl_before = alu_ctrl;
      @(posedge clk);
      #1;
      set_req(v.id, 1'b0, 4'd0, 4'd0, 4'd0);
      set_req(~v.id, 1'b1, 4'd0, 4'd1, 4'd1);
      lat  = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         lat++;
         chk("busy_ready0", req0_ready, 1'b0);
         chk("busy_ready1", req1_ready, 1'b0);
         if (rsp_valid) begin
            done = 1'b1;
         end else begin
            if (!v.err) begin
               chk("exec_alu_ctrl", alu_ctrl, v.op);
               chk("exec_alu_a", alu_a, v.a);
               chk("exec_alu_b", alu_b, v.b);
            end
            if (lat > 20) begin
               chk("rsp_timeout", 1'b0, 1'b1);
               done = 1'b1;
            end
         end
      end
      chk("rsp_latency", lat, v.lat);
      chk("rsp_result", rsp_result, v.res);
      chk("rsp_err", rsp_err, v.err);
      chk("rsp_id", rsp_id, v.id);
      if (v.err) chk("err_alu_ctrl_kept", alu_ctrl, ctrl_before);
      @(posedge clk);
      #1;
      set_req(~v.id, 1'b0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      chk("rsp_drop", rsp_valid, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int grants;
      int cyc;
      bit seen;

      tbl[0]  = '{1'b0, 4'd0, 4'd3,  4'd4,  2, 4'd7,  1'b0};
      tbl[1]  = '{1'b1, 4'd2, 4'd3,  4'd2,  3, 4'd6,  1'b0};
      tbl[2]  = '{1'b0, 4'd3, 4'd9,  4'd2,  5, 4'd4,  1'b0};
      tbl[3]  = '{1'b1, 4'd1, 4'd5,  4'd7,  2, 4'd14, 1'b0};
      tbl[4]  = '{1'b0, 4'd4, 4'd3,  4'd2,  2, 4'd12, 1'b0};
      tbl[5]  = '{1'b1, 4'd5, 4'd12, 4'd2,  2, 4'd3,  1'b0};
      tbl[6]  = '{1'b0, 4'd6, 4'd12, 4'd10, 2, 4'd8,  1'b0};
      tbl[7]  = '{1'b1, 4'd7, 4'd12, 4'd3,  2, 4'd15, 1'b0};
      tbl[8]  = '{1'b0, 4'd8, 4'd12, 4'd10, 2, 4'd6,  1'b0};
      tbl[9]  = '{1'b1, 4'd9, 4'd5,  4'd0,  2, 4'd10, 1'b0};
      tbl[10] = '{1'b0, 4'd3, 4'd7,  4'd0,  1, 4'd15, 1'b1};
      tbl[11] = '{1'b1, 4'd12, 4'd5, 4'd5,  1, 4'd0,  1'b1};
      tbl[12] = '{1'b0, 4'd2, 4'd7,  4'd3,  3, 4'd5,  1'b0};

      rst = 1'b1;
      rsp_ready = 1'b1;
      set_req(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req0_ready", req0_ready, 1'b0);
      chk("rst_alu_a", alu_a, 4'd0);
      chk("rst_alu_b", alu_b, 4'd0);
      chk("rst_alu_ctrl", alu_ctrl, 4'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 1'b0);
      chk("rst_rsp_result", rsp_result, 4'd0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req0_ready", req0_ready, 1'b1);
      set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) run_op(tbl[i]);

      // Both requesters always valid: grants must alternate starting at 0.
      do_reset();
      set_req(1'b0, 1'b1, 4'd0, 4'd1, 4'd1);
      set_req(1'b1, 1'b1, 4'd0, 4'd2, 4'd2);
      grants = 0;
      cyc    = 0;
      while (grants < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (req0_ready || req1_ready) begin
            chk("rr_one_ready", req0_ready & req1_ready, 1'b0);
            chk("rr_grant", req1_ready, grants % 2);
            grants++;
         end
         if (rsp_valid) begin
            chk("rr_resp_no_ready", req0_ready | req1_ready, 1'b0);
            chk("rr_rsp_result", rsp_result, rsp_id ? 4'd4 : 4'd2);
         end
      end
      chk("rr_grant_count", grants, 4);
      set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      @(posedge clk);
      #1;
      cyc = 0;
      while (cyc < 20 && (rsp_valid || req0_ready || req1_ready || cyc < 6)) begin
         @(posedge clk);
         #1;
         cyc++;
      end

      // Backpressure: response held for three cycles with rsp_ready low.
      rsp_ready = 1'b0;
      set_req(1'b0, 1'b1, 4'd0, 4'd2, 4'd2);
      @(posedge clk);
      #1;
      set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      set_req(1'b1, 1'b1, 4'd0, 4'd1, 4'd1);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         seen = rsp_valid;
      end
      chk("bp_rsp_seen", seen, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid", rsp_valid, 1'b1);
         chk("bp_result", rsp_result, 4'd4);
         chk("bp_id", rsp_id, 1'b0);
         chk("bp_err", rsp_err, 1'b0);
         chk("bp_readys", req0_ready | req1_ready, 1'b0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      @(posedge clk);
      #1;

      // Reset during the second DIV execute cycle discards the operation.
      set_req(1'b1, 1'b1, 4'd3, 4'd9, 4'd3);
      @(negedge clk);
      chk("rdiv_ready", req1_ready, 1'b1);
      @(posedge clk);
      #1;
      set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      @(posedge clk);
      #2;
      chk("rdiv_in_exec", alu_ctrl, 4'd3);
      set_req(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      rst = 1'b1;
      #1;
      chk("rdiv_alu_ctrl", alu_ctrl, 4'd0);
      chk("rdiv_alu_a", alu_a, 4'd0);
      chk("rdiv_rsp_valid", rsp_valid, 1'b0);
      chk("rdiv_ready_in_rst", req0_ready, 1'b0);
      repeat (2) @(posedge clk);
      set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      #1 rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("rdiv_no_rsp", seen, 1'b0);
      set_req(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
      set_req(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
      #1;
      chk("rdiv_tie_req0", req0_ready, 1'b1);
      chk("rdiv_tie_req1", req1_ready, 1'b0);
      set_req(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      set_req(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
      @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
